// File: rtl/serial_tx.sv
// serial_tx: UART-style serializer sending start, 8 data bits LSB first, optional parity, stop.
// Define SERIAL_TX_PARITY_EN to include the PARITY state and parity bit (11-bit frame).
module serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic       data_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  // Reject parameter values outside the supported range at elaboration.
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 255 || PARITY_ODD > 1) begin : g_param_check
    $error("serial_tx: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [IDX_W-1:0]    idx_next;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                data_out_d;
  logic                busy_d;
  logic                done_d;
  logic                period_end;
`ifdef SERIAL_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  assign period_end = (cnt_q == CNT_LAST);
  assign idx_next   = bit_idx_q + IDX_W'(1);

  // State, counters and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      data_out  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      data_out  <= data_out_d;
      busy      <= busy_d;
      done      <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // Next state plus the line value for the following cycle, so data_out stays registered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    data_out_d = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_d      = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (send) begin
          data_d     = data_in;
`ifdef SERIAL_TX_PARITY_EN
          par_d      = (^data_in) ^ 1'(PARITY_ODD);
`endif
          cnt_d      = '0;
          bit_idx_d  = '0;
          state_d    = START;
          data_out_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      START: begin
        busy_d = 1'b1;
        if (period_end) begin
          cnt_d      = '0;
          bit_idx_d  = '0;
          state_d    = DATA;
          data_out_d = data_q[0];
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          data_out_d = 1'b0;
        end
      end

      DATA: begin
        busy_d = 1'b1;
        if (period_end) begin
          cnt_d = '0;
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d  = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d    = PARITY;
            data_out_d = par_q;
`else
            state_d    = STOP;
            data_out_d = 1'b1;
`endif
          end else begin
            bit_idx_d  = idx_next;
            data_out_d = data_q[idx_next];
          end
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          data_out_d = data_q[bit_idx_q];
        end
      end

`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        busy_d = 1'b1;
        if (period_end) begin
          cnt_d      = '0;
          state_d    = STOP;
          data_out_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          data_out_d = par_q;
        end
      end
`endif

      STOP: begin
        data_out_d = 1'b1;
        if (period_end) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        bit_idx_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: even- and odd-parity instances share stimulus; a queue model checks every cycle.
module tb_serial_tx;

  localparam int unsigned CPB = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned FB = 11;
`else
  localparam int unsigned FB = 10;
`endif
  localparam int unsigned NCYC = FB * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [7:0] data_in;
  logic       d0_out, busy0, done0;
  logic       d1_out, busy1, done1;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut_even (
    .clk(clk), .rst(rst), .data_in(data_in), .send(send),
    .data_out(d0_out), .busy(busy0), .done(done0)
  );

  serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .data_in(data_in), .send(send),
    .data_out(d1_out), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one queue entry per future line cycle, {odd_line, even_line}.
  logic [1:0] mq[$];
  bit         m_done = 1'b0;

  task automatic push_frame(input logic [7:0] d);
    logic [1:0] bits [11];
    bits[0] = 2'b00;
    for (int i = 0; i < 8; i++) bits[i+1] = {2{d[i]}};
`ifdef SERIAL_TX_PARITY_EN
    bits[9]  = {~(^d), ^d};
    bits[10] = 2'b11;
`else
    bits[9]  = 2'b11;
    bits[10] = 2'b11;
`endif
    for (int b = 0; b < int'(FB); b++)
      for (int c = 0; c < int'(CPB); c++) mq.push_back(bits[b]);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_done = 1'b0;
    end else if (mq.size() != 0) begin
      void'(mq.pop_front());
      m_done = (mq.size() == 0);
    end else begin
      m_done = 1'b0;
      if (send) push_frame(data_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] line;
      logic       mb;
      line = (mq.size() != 0) ? mq[0] : 2'b11;
      mb   = (mq.size() != 0);
      check("cycle_model", 32'({d1_out, d0_out, busy1, busy0, done1, done0}),
            32'({line[1], line[0], mb, mb, m_done, m_done}));
    end
  end

  function automatic logic [10:0] exp_frame(input logic [7:0] d, input logic p);
    logic [10:0] f;
    f      = '0;
    f[8:1] = d;
`ifdef SERIAL_TX_PARITY_EN
    f[9]   = p;
    f[10]  = 1'b1;
`else
    f[9]   = 1'b1 | p;
`endif
    return f;
  endfunction

  // Call just after the accepting edge; samples mid-bit and returns at the done cycle.
  task automatic capture(output logic [10:0] f0, output logic [10:0] f1, output int bc,
                         output bit dn_ok, output bit first_ok);
    f0 = '0; f1 = '0; bc = 0; dn_ok = 1'b1; first_ok = 1'b0;
    for (int k = 0; k < int'(NCYC); k++) begin
      @(negedge clk);
      if (k == 0) first_ok = (d0_out === 1'b0 && d1_out === 1'b0 && busy0 === 1'b1);
      if (busy0 === 1'b1) bc++;
      if (done0 !== 1'b0 || done1 !== 1'b0) dn_ok = 1'b0;
      if (k % int'(CPB) == int'(CPB) / 2) begin
        f0[k / int'(CPB)] = d0_out;
        f1[k / int'(CPB)] = d1_out;
      end
    end
    @(negedge clk);
    if (!(done0 === 1'b1 && done1 === 1'b1 && busy0 === 1'b0 && busy1 === 1'b0)) dn_ok = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       po;
  } vec_t;

  vec_t tbl [8];

  task automatic run_frame(input int i);
    logic [10:0] f0, f1;
    int          bc;
    bit          dn_ok, first_ok;
    data_in = tbl[i].d;
    send    = 1'b1;
    @(posedge clk);
    #1 send = 1'b0;
    capture(f0, f1, bc, dn_ok, first_ok);
    check("frame_even", 32'(f0), 32'(exp_frame(tbl[i].d, tbl[i].pe)));
    check("frame_odd",  32'(f1), 32'(exp_frame(tbl[i].d, tbl[i].po)));
    check("busy_len",   32'(bc), 32'(NCYC));
    check("done_pulse", 32'(dn_ok), 32'd1);
    check("start_first", 32'(first_ok), 32'd1);
  endtask

  initial begin
    logic [10:0] f0, f1;
    int          bc;
    bit          dn_ok, first_ok, saw_done;

    tbl[0] = '{8'hA5, 1'b0, 1'b1};
    tbl[1] = '{8'h00, 1'b0, 1'b1};
    tbl[2] = '{8'hFF, 1'b0, 1'b1};
    tbl[3] = '{8'h81, 1'b0, 1'b1};
    tbl[4] = '{8'h01, 1'b1, 1'b0};
    tbl[5] = '{8'h07, 1'b1, 1'b0};
    tbl[6] = '{8'h5A, 1'b0, 1'b1};
    tbl[7] = '{8'h80, 1'b1, 1'b0};

    rst = 1'b1; send = 1'b1; data_in = 8'hA5;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({d0_out, d1_out, busy0, busy1, done0, done1}), 32'(6'b110000));
    chk_en = 1'b1;
    rst    = 1'b0;

    // Table frames; the first is accepted on the first edge after reset releases.
    for (int i = 0; i < 8; i++) begin
      run_frame(i);
      repeat (i % 3) @(negedge clk);
    end

    // Send held high: back-to-back frames, second carries the byte present at its acceptance.
    @(negedge clk);
    data_in = 8'h3C; send = 1'b1;
    @(posedge clk);
    #1;
    fork
      capture(f0, f1, bc, dn_ok, first_ok);
      begin repeat (30) @(negedge clk); data_in = 8'hC3; end
    join
    check("b2b_frame1", 32'(f0), 32'(exp_frame(8'h3C, 1'b0)));
    check("b2b_done1",  32'(dn_ok), 32'd1);
    @(posedge clk);
    #1 send = 1'b0;
    capture(f0, f1, bc, dn_ok, first_ok);
    check("b2b_start2", 32'(first_ok), 32'd1);
    check("b2b_frame2", 32'(f1), 32'(exp_frame(8'hC3, 1'b1)));
    check("b2b_busy2",  32'(bc), 32'(NCYC));

    // Send and data_in changes while busy are ignored.
    @(negedge clk);
    data_in = 8'h96; send = 1'b1;
    @(posedge clk);
    #1 send = 1'b0;
    fork
      capture(f0, f1, bc, dn_ok, first_ok);
      begin
        repeat (15) @(negedge clk);
        data_in = 8'h69; send = 1'b1;
        @(negedge clk) send = 1'b0;
        repeat (30) @(negedge clk);
        data_in = 8'hFF; send = 1'b1;
        @(negedge clk) send = 1'b0;
      end
    join
    check("busy_ign_frame", 32'(f0), 32'(exp_frame(8'h96, 1'b0)));
    check("busy_ign_busy",  32'(bc), 32'(NCYC));

    // Reset during data bit 3 (cycles 33..40 after acceptance) aborts without done.
    repeat (2) @(negedge clk);
    data_in = 8'h00; send = 1'b1;
    @(posedge clk);
    #1 send = 1'b0;
    repeat (35) @(negedge clk);
    check("pre_rst_line", 32'({d0_out, busy0}), 32'(2'b01));
    rst = 1'b1;
    @(negedge clk);
    check("post_rst", 32'({d0_out, d1_out, busy0, busy1, done0, done1}), 32'(6'b110000));
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (done0 !== 1'b0 || done1 !== 1'b0) saw_done = 1'b1;
    end
    check("no_done_after_abort", 32'(saw_done), 32'd0);
    run_frame(6);

    // Random traffic, checked cycle by cycle against the queue model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      data_in = 8'($urandom);
      send    = ($urandom_range(0, 3) == 0);
      rst     = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0; send = 1'b0;
    repeat (NCYC + 4) @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
